// File: rtl/ysyx_23060184_clint_if.sv
// Bus bundle for the CLINT register port: AXI-lite style read channel
// (ar/r) and write channels (aw/w/b).
//   slave  : seen by the CLINT (addresses, write data, ready-to-accept responses in)
//   master : seen by the requester (the mirror image)
interface ysyx_23060184_clint_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]             araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [31:0]             awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060184_clint.sv
// Core-local interruptor: free-running 64-bit mtime with a prescaler, a 64-bit
// mtimecmp, and a registered machine timer interrupt (mtip = mtime >= mtimecmp).
// Registers are reached through an AXI-lite style slave port with independent
// read and write state machines.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : register bus (slave modport); registers are 32-bit halves, so
//          DATA_WIDTH is expected to be 32
//   mtip : machine timer interrupt pending
module ysyx_23060184_clint #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE       = 32'h0200_0000,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060184_clint_if.slave        bus,
  output logic                        mtip
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {RegNone, RegCmpLo, RegCmpHi, RegTimeLo, RegTimeHi} reg_sel_e;
  typedef enum logic {StRIdle, StRResp} rd_state_e;
  typedef enum logic [1:0] {StWIdle, StWData, StWAddr, StWResp} wr_state_e;

  function automatic reg_sel_e decode(logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (addr[1:0] != 2'b00) return RegNone;
    case (off)
      32'h0000_4000: return RegCmpLo;
      32'h0000_4004: return RegCmpHi;
      32'h0000_BFF8: return RegTimeLo;
      32'h0000_BFFC: return RegTimeHi;
      default:       return RegNone;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [DATA_WIDTH-1:0] data,
                                        logic [DATA_WIDTH/8-1:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Timer state
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] presc_q, presc_d;
  logic        mtip_q;
  logic        tick;

  // Read side
  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [31:0]           rd_word;
  logic                  rd_hit;
  logic                  rd_capture;

  // Write side
  wr_state_e               wr_state_q, wr_state_d;
  logic [31:0]             awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0]              bresp_q;
  logic                    wr_commit;
  logic [31:0]             wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  reg_sel_e                wr_sel;

  // ---------------------------------------------------------------- read FSM
  always_ff @(posedge clk) begin
    if (rst) rd_state_q <= StRIdle;
    else     rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      StRIdle: if (bus.arvalid) rd_state_d = StRResp;
      StRResp: if (bus.rready)  rd_state_d = StRIdle;
    endcase
  end

  always_comb begin
    bus.arready = (rd_state_q == StRIdle);
    bus.rvalid  = (rd_state_q == StRResp);
    bus.rdata   = rdata_q;
    bus.rresp   = rresp_q;
  end

  assign rd_capture = (rd_state_q == StRIdle) && bus.arvalid;

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b1;
    case (decode(bus.araddr))
      RegCmpLo:  rd_word = mtimecmp_q[31:0];
      RegCmpHi:  rd_word = mtimecmp_q[63:32];
      RegTimeLo: rd_word = mtime_q[31:0];
      RegTimeHi: rd_word = mtime_q[63:32];
      default:   rd_hit  = 1'b0;
    endcase
  end

  // Captured from the pre-update register values, so a read coinciding with
  // a commit to the same register returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= RespOkay;
    end else if (rd_capture) begin
      rdata_q <= DATA_WIDTH'(rd_word);
      rresp_q <= rd_hit ? RespOkay : RespSlvErr;
    end
  end

  // --------------------------------------------------------------- write FSM
  always_ff @(posedge clk) begin
    if (rst) wr_state_q <= StWIdle;
    else     wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      StWIdle: begin
        if (bus.awvalid && bus.wvalid) wr_state_d = StWResp;
        else if (bus.awvalid)          wr_state_d = StWData;
        else if (bus.wvalid)           wr_state_d = StWAddr;
      end
      StWData: if (bus.wvalid)  wr_state_d = StWResp;
      StWAddr: if (bus.awvalid) wr_state_d = StWResp;
      StWResp: if (bus.bready)  wr_state_d = StWIdle;
    endcase
  end

  always_comb begin
    bus.awready = (wr_state_q == StWIdle) || (wr_state_q == StWAddr);
    bus.wready  = (wr_state_q == StWIdle) || (wr_state_q == StWData);
    bus.bvalid  = (wr_state_q == StWResp);
    bus.bresp   = bresp_q;
  end

  // Pick the address/data halves from the live bus or from whichever half was
  // latched while waiting for its partner.
  always_comb begin
    wr_commit = 1'b0;
    wr_addr   = bus.awaddr;
    wr_data   = bus.wdata;
    wr_strb   = bus.wstrb;
    unique case (wr_state_q)
      StWIdle: wr_commit = bus.awvalid && bus.wvalid;
      StWData: begin
        wr_commit = bus.wvalid;
        wr_addr   = awaddr_q;
      end
      StWAddr: begin
        wr_commit = bus.awvalid;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
      end
      StWResp: wr_commit = 1'b0;
    endcase
  end

  assign wr_sel = decode(wr_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RespOkay;
    end else begin
      if (wr_state_q == StWIdle && bus.awvalid && !bus.wvalid) awaddr_q <= bus.awaddr;
      if (wr_state_q == StWIdle && bus.wvalid && !bus.awvalid) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
      if (wr_commit) bresp_q <= (wr_sel == RegNone) ? RespSlvErr : RespOkay;
    end
  end

  // ------------------------------------------------------------------- timer
  assign tick = (presc_q == 32'(PRESCALE - 1));

  // A commit to mtime merges into the pre-tick value, dropping that tick.
  always_comb begin
    presc_d    = tick ? 32'd0 : presc_q + 32'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_commit) begin
      case (wr_sel)
        RegCmpLo:  mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wr_data, wr_strb);
        RegCmpHi:  mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wr_data, wr_strb);
        RegTimeLo: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wr_strb)};
        RegTimeHi: mtime_d = {merge(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  assign mtip = mtip_q;

endmodule

// File: tb/tb_ysyx_23060184_clint.sv
// Self-checking bench for ysyx_23060184_clint. A timeline model gives mtime as
// an anchor value plus elapsed cycles; table-driven and random bus traffic is
// compared with it, plus hand-written sequences for the timing corner cases.
// A second instance with PRESCALE=3 checks the prescaler.
module tb_ysyx_23060184_clint;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mtip, mtip3;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference timeline: mtime after edge c = anchor_val + (c - anchor_cyc)
  logic [63:0] anchor_val = '0;
  int          anchor_cyc = 0;
  logic [63:0] cmp_m = '1;
  int          reset_cyc = 0;

  ysyx_23060184_clint_if #(.DATA_WIDTH(32)) bus ();
  ysyx_23060184_clint_if #(.DATA_WIDTH(32)) bus3 ();

  ysyx_23060184_clint #(.DATA_WIDTH(32), .BASE(BASE), .PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .mtip(mtip)
  );
  ysyx_23060184_clint #(.DATA_WIDTH(32), .BASE(BASE), .PRESCALE(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .mtip(mtip3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  resp;
  } rd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    int          bdel;
    logic [1:0]  resp;
  } wr_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] data, logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mtime_at(int c);
    return anchor_val + 64'(c - anchor_cyc);
  endfunction

  function automatic logic [33:0] model_read(logic [31:0] addr, int c);
    logic [63:0] t;
    t = mtime_at(c);
    if (addr[1:0] != 2'b00) return {2'b10, 32'h0};
    case (addr - BASE)
      32'h4000: return {2'b00, cmp_m[31:0]};
      32'h4004: return {2'b00, cmp_m[63:32]};
      32'hBFF8: return {2'b00, t[31:0]};
      32'hBFFC: return {2'b00, t[63:32]};
      default:  return {2'b10, 32'h0};
    endcase
  endfunction

  // Apply a write committed at edge c; returns the expected bresp.
  function automatic logic [1:0] model_write(logic [31:0] addr, logic [31:0] data,
                                             logic [3:0] strb, int c);
    logic [63:0] t;
    if (addr[1:0] != 2'b00) return 2'b10;
    t = mtime_at(c - 1);
    case (addr - BASE)
      32'h4000: cmp_m[31:0]  = merge(cmp_m[31:0], data, strb);
      32'h4004: cmp_m[63:32] = merge(cmp_m[63:32], data, strb);
      32'hBFF8: begin
        t[31:0] = merge(t[31:0], data, strb);
        anchor_val = t;
        anchor_cyc = c;
      end
      32'hBFFC: begin
        t[63:32] = merge(t[63:32], data, strb);
        anchor_val = t;
        anchor_cyc = c;
      end
      default: return 2'b10;
    endcase
    return 2'b00;
  endfunction

  function automatic logic exp_mtip();
    return mtime_at(cyc - 1) >= cmp_m;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    anchor_val = '0;
    anchor_cyc = cyc;
    reset_cyc  = cyc;
    cmp_m      = '1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdel, input string name,
                         output logic [31:0] data, output logic [1:0] resp);
    logic [33:0] exp;
    chk({name, "_arready"}, bus.arready, 1'b1);
    exp = model_read(addr, cyc);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    step();
    bus.arvalid = 1'b0;
    bus.araddr  = ~addr;
    data = bus.rdata;
    resp = bus.rresp;
    chk({name, "_rvalid"}, bus.rvalid, 1'b1);
    chk({name, "_rdata"}, bus.rdata, exp[31:0]);
    chk({name, "_rresp"}, bus.rresp, exp[33:32]);
    for (int k = 0; k < rdel; k++) begin
      step();
      chk({name, "_rvalid_hold"}, bus.rvalid, 1'b1);
      chk({name, "_rdata_hold"}, bus.rdata, data);
      chk({name, "_arready_busy"}, bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    chk({name, "_rvalid_done"}, bus.rvalid, 1'b0);
  endtask

  // lead > 0: address first by lead cycles; lead < 0: data first; 0: together.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int bdel,
                          input string name, output int commit, output logic [1:0] bresp);
    logic [1:0] exp;
    if (lead >= 0) begin
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
    end
    if (lead <= 0) begin
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wvalid = 1'b1;
    end
    step();
    if (lead > 0) begin
      bus.awvalid = 1'b0;
      bus.awaddr  = addr ^ 32'h0000_0100;
      chk({name, "_awready_wait"}, bus.awready, 1'b0);
      chk({name, "_wready_wait"}, bus.wready, 1'b1);
      for (int k = 1; k < lead; k++) step();
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wvalid = 1'b1;
      step();
    end else if (lead < 0) begin
      bus.wvalid = 1'b0;
      bus.wdata  = ~data;
      bus.wstrb  = ~strb;
      chk({name, "_wready_wait"}, bus.wready, 1'b0);
      chk({name, "_awready_wait"}, bus.awready, 1'b1);
      for (int k = 1; k < -lead; k++) step();
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      step();
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    commit = cyc;
    exp = model_write(addr, data, strb, commit);
    bresp = bus.bresp;
    chk({name, "_bvalid"}, bus.bvalid, 1'b1);
    chk({name, "_bresp"}, bus.bresp, exp);
    for (int k = 0; k < bdel; k++) begin
      step();
      chk({name, "_bvalid_hold"}, bus.bvalid, 1'b1);
      chk({name, "_bresp_hold"}, bus.bresp, exp);
      chk({name, "_awready_busy"}, bus.awready, 1'b0);
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk({name, "_bvalid_done"}, bus.bvalid, 1'b0);
  endtask

  rd_vec_t rd_tab[6];
  wr_vec_t wr_tab[5];

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r;
    logic [33:0] e;
    int          w, w2, exp3;

    rd_tab[0] = '{BASE + 32'h0000, 2'b10};
    rd_tab[1] = '{BASE + 32'h4002, 2'b10};
    rd_tab[2] = '{BASE + 32'h4000, 2'b00};
    rd_tab[3] = '{BASE + 32'h4004, 2'b00};
    rd_tab[4] = '{BASE + 32'hBFFC, 2'b00};
    rd_tab[5] = '{BASE + 32'hBFFB, 2'b10};

    wr_tab[0] = '{BASE + 32'h1234, 32'h1234_5678, 4'hF, 0, 0, 2'b10};
    wr_tab[1] = '{BASE + 32'h4002, 32'hCAFE_F00D, 4'hF, 1, 1, 2'b10};
    wr_tab[2] = '{BASE + 32'h4004, 32'h0000_0000, 4'hF, -2, 0, 2'b00};
    wr_tab[3] = '{BASE + 32'h4000, 32'h0000_0005, 4'hF, 0, 2, 2'b00};
    wr_tab[4] = '{BASE + 32'hBFFC, 32'h0000_0000, 4'b1100, 2, 0, 2'b00};

    bus.araddr = '0;  bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0;  bus.awvalid = 1'b0; bus.wdata  = '0;
    bus.wstrb  = '0;  bus.wvalid  = 1'b0; bus.bready = 1'b0;
    bus3.araddr = '0; bus3.arvalid = 1'b0; bus3.rready = 1'b0;
    bus3.awaddr = '0; bus3.awvalid = 1'b0; bus3.wdata  = '0;
    bus3.wstrb  = '0; bus3.wvalid  = 1'b0; bus3.bready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_arready", bus.arready, 1'b1);
    chk("rst_awready", bus.awready, 1'b1);
    chk("rst_wready", bus.wready, 1'b1);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_mtip", mtip, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_rresp", bus.rresp, 2'b00);
    chk("rst_bresp", bus.bresp, 2'b00);

    // Idle 10 cycles then read mtime
    repeat (10) step();
    do_read(BASE + 32'hBFF8, 0, "idle10", d, r);
    chk("idle10_window", (d >= 32'd10 && d <= 32'd12), 1'b1);

    // Prescaler of 3 on the second instance, three distinct phases
    for (int k = 0; k < 3; k++) begin
      exp3 = (cyc - reset_cyc) / 3;
      bus3.araddr  = BASE + 32'hBFF8;
      bus3.arvalid = 1'b1;
      step();
      bus3.arvalid = 1'b0;
      chk("presc3_rvalid", bus3.rvalid, 1'b1);
      chk("presc3_mtime", bus3.rdata, 64'(exp3));
      bus3.rready = 1'b1;
      step();
      bus3.rready = 1'b0;
    end

    // Table-driven reads
    for (int i = 0; i < 6; i++) begin
      do_read(rd_tab[i].addr, i % 3, "rdtab", d, r);
      chk("rdtab_resp", r, rd_tab[i].resp);
    end

    // aw 3 cycles before w, partial strobe, late bready
    do_reset();
    do_write(BASE + 32'h4000, 32'hDEAD_BEEF, 4'b0011, 3, 4, "strb", w, r);
    do_read(BASE + 32'h4000, 0, "strb_rd", d, r);
    chk("strb_value", d, 32'hFFFF_BEEF);

    // Table-driven writes
    for (int i = 0; i < 5; i++) begin
      do_write(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].strb, wr_tab[i].lead,
               wr_tab[i].bdel, "wrtab", w, r);
      chk("wrtab_resp", r, wr_tab[i].resp);
    end
    do_read(BASE + 32'h4000, 0, "after_cmplo", d, r);
    chk("cmplo_is_5", d, 32'h5);
    do_read(BASE + 32'h4004, 0, "after_cmphi", d, r);
    chk("cmphi_is_0", d, 32'h0);

    // mtip rises exactly one cycle after mtime reaches mtimecmp (5)
    do_write(BASE + 32'hBFF8, 32'h0, 4'hF, 0, 0, "mtime0", w, r);
    for (int k = 0; k < 10; k++) begin
      chk("mtip_rise", mtip, ((cyc - w) >= 6));
      chk("mtip_model", mtip, exp_mtip());
      step();
    end

    // Read and commit to the same register in one cycle: read sees old value
    e = model_read(BASE + 32'h4000, cyc);
    bus.araddr = BASE + 32'h4000; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 32'h4000; bus.awvalid = 1'b1;
    bus.wdata  = 32'h77;          bus.wstrb   = 4'hF; bus.wvalid = 1'b1;
    step();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    r = model_write(BASE + 32'h4000, 32'h77, 4'hF, cyc);
    chk("same_cyc_rdata_old", bus.rdata, e[31:0]);
    chk("same_cyc_old_is_5", bus.rdata, 32'h5);
    chk("same_cyc_bvalid", bus.bvalid, 1'b1);
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;
    do_read(BASE + 32'h4000, 0, "same_cyc_after", d, r);
    chk("same_cyc_new", d, 32'h77);

    // 64-bit wrap
    do_write(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, "wrap_hi", w, r);
    do_write(BASE + 32'hBFF8, 32'hFFFF_FFFE, 4'hF, 0, 0, "wrap_lo", w2, r);
    chk("wrap_mtip_model0", mtip, exp_mtip());
    do_read(BASE + 32'hBFFC, 0, "wrap_rd1", d, r);
    chk("wrap_max_hi", d, 32'hFFFF_FFFF);
    do_read(BASE + 32'hBFF8, 0, "wrap_rd2", d, r);
    chk("wrap_lo_after", d, 32'h1);
    do_read(BASE + 32'hBFFC, 0, "wrap_rd3", d2, r);
    chk("wrap_hi_zero", d2, 32'h0);
    chk("wrap_mtip_model1", mtip, exp_mtip());

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: a = BASE + 32'h4000;
        1: a = BASE + 32'h4004;
        2: a = BASE + 32'hBFF8;
        3: a = BASE + 32'hBFFC;
        4: a = BASE + ($urandom & 32'h0000_FFFC);
        default: a = BASE + 32'h4000 + 32'($urandom_range(1, 3));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, int'($urandom_range(0, 2)), "rnd_rd", d, r);
      end else begin
        do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                 int'($urandom_range(0, 3)), "rnd_wr", w, r);
      end
      chk("rnd_mtip", mtip, exp_mtip());
    end

    // Reset while a read response is pending
    bus.araddr = BASE + 32'hBFF8; bus.arvalid = 1'b1; bus.rready = 1'b0;
    step();
    bus.arvalid = 1'b0;
    chk("rst_mid_rvalid_pre", bus.rvalid, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_mid_rvalid", bus.rvalid, 1'b0);
    step();
    rst = 1'b0;
    anchor_val = '0;
    anchor_cyc = cyc;
    reset_cyc  = cyc;
    cmp_m      = '1;
    chk("rst_mid_arready", bus.arready, 1'b1);
    chk("rst_mid_awready", bus.awready, 1'b1);
    chk("rst_mid_wready", bus.wready, 1'b1);
    do_read(BASE + 32'hBFF8, 0, "rst_mid_mtime", d, r);
    chk("rst_mid_mtime_zero", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
